rsa_stream_io: RTL and testbench
================================

RSA_STREAM_IO -- requirements
Module: rsa_stream_io

Interface
REQ-001 Parameter MOD_WIDTH, default 256, is the key width in bits and matches KeyType from RSA_pkg.
REQ-002 Parameter WORD_WIDTH, default 32, is the host word width; MOD_WIDTH SHALL be a multiple of it; WORDS = MOD_WIDTH/WORD_WIDTH.
REQ-003 Port clk, input, 1: the single clock.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port s_valid, input, 1: host input word valid.
REQ-006 Port s_ready, output, 1: block accepts a host word.
REQ-007 Port s_data, input, WORD_WIDTH: host input word.
REQ-008 Port m_valid, output, 1: operand set valid toward the exponentiator.
REQ-009 Port m_ready, input, 1: exponentiator accepts the operand set.
REQ-010 Ports m_base, m_msg, m_key, m_modulus, output, MOD_WIDTH each: assembled operands (2^2n mod N, message, exponent e, N).
REQ-011 Port r_valid, input, 1: exponentiator result valid.
REQ-012 Port r_ready, output, 1: block accepts the result.
REQ-013 Port r_crypto, input, MOD_WIDTH: exponentiation result.
REQ-014 Ports o_valid (output, 1), o_ready (input, 1), o_data (output, WORD_WIDTH): host result word stream.

Function
REQ-015 FSM states SHALL be LOAD, ISSUE, WAIT and UNLOAD; one transaction in flight at a time.
REQ-016 LOAD: s_ready=1; each s_valid&&s_ready writes s_data into word (cnt mod WORDS) of operand (cnt / WORDS); operand order base, msg, key, modulus; least-significant word first; cnt increments.
REQ-017 On the handshake at cnt=4*WORDS-1: cnt clears and the state moves to ISSUE on the next edge; m_valid SHALL rise exactly 1 cycle after that handshake.
REQ-018 ISSUE: m_valid=1 and m_* held stable until m_valid&&m_ready, then WAIT; s_ready=0 in every state other than LOAD.
REQ-019 WAIT: r_ready=1; on r_valid&&r_ready, r_crypto is captured into the result register and the state moves to UNLOAD; r_valid outside WAIT is ignored.
REQ-020 UNLOAD: o_valid=1, o_data = result word cnt (LSW first), held stable while o_ready=0; each handshake increments cnt; the handshake at cnt=WORDS-1 returns the FSM to LOAD with cnt=0.
REQ-021 Throughput: one word per cycle in LOAD and UNLOAD under continuous valid/ready.
REQ-022 m_* outputs SHALL keep the last loaded values outside ISSUE; they are overwritten only by LOAD handshakes.

Reset
REQ-023 While rst=0: state=LOAD, cnt=0, operand and result registers cleared; s_ready=1, m_valid=0, r_ready=0, o_valid=0, o_data=0, m_*=0.
REQ-024 Reset asserted in any state, including mid-LOAD or mid-UNLOAD, SHALL abandon the transaction; the next accepted word is base word 0.

Configuration
REQ-025 Macro RSA_STREAM_ODD_CHECK_EN: when defined, port o_err (output, 1, reset 0) exists; if m_modulus[0]=0 at end of LOAD, the FSM skips ISSUE/WAIT, enters UNLOAD with an all-zero result, and sets o_err; o_err clears on the first handshake of the next LOAD.
REQ-026 Without RSA_STREAM_ODD_CHECK_EN: no o_err port, no check; every transaction goes through ISSUE and WAIT.

Verification
REQ-027 Words k+1 for k=0..31, m_ready=1 -> m_base[31:0]=1, m_base[255:224]=8, m_msg[31:0]=9, m_key[31:0]=17, m_modulus[31:0]=25, m_valid 1 cycle after word 31.
REQ-028 m_ready held 0 for 5 cycles in ISSUE -> m_valid stays 1, m_* unchanged, s_ready=0, r_valid pulses ignored.
REQ-029 r_crypto=256'h0807060504030201 with o_ready toggling 1/0 -> o_data sequence 0x04030201, 0x08070605, then six 0x0; each word stable until accepted.
REQ-030 rst pulsed low after 10 input words -> s_ready=1, m_valid=0; the following 32 words form a correct fresh transaction.
REQ-031 With RSA_STREAM_ODD_CHECK_EN, modulus word 0 = 0x20 -> m_valid never rises, o_err=1, eight zero output words, o_err=0 after the next input word.

Source files
------------

// File: rtl/rsa_stream_io.sv
// rsa_stream_io: host-word stream adapter around a modular exponentiator.
// Collects base, message, exponent and modulus from the host one word at a
// time (least-significant word first), hands the full operand set to the
// exponentiator, waits for its result and streams the result back out to the
// host one word at a time. One transaction is in flight at a time.
//
// Optional feature, enabled by defining RSA_STREAM_ODD_CHECK_EN:
//   adds output o_err. An even modulus at the end of loading skips the
//   exponentiator and returns an all-zero result with o_err raised.
//   o_err drops on the first accepted word of the following load.
module rsa_stream_io #(
  parameter int MOD_WIDTH  = 256,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // host input word stream
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  // operand set toward the exponentiator
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [MOD_WIDTH-1:0]  m_base,
  output logic [MOD_WIDTH-1:0]  m_msg,
  output logic [MOD_WIDTH-1:0]  m_key,
  output logic [MOD_WIDTH-1:0]  m_modulus,
  // result from the exponentiator
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [MOD_WIDTH-1:0]  r_crypto,
  // host result word stream
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [WORD_WIDTH-1:0] o_data
`ifdef RSA_STREAM_ODD_CHECK_EN
  ,
  output logic                  o_err
`endif
);

  localparam int WORDS    = MOD_WIDTH / WORD_WIDTH;
  localparam int OP_WORDS = 4 * WORDS;
  localparam int CNT_W    = $clog2(OP_WORDS);

  // last word index of the load phase (final modulus word)
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(OP_WORDS - 1);
  // last word index of the unload phase (most-significant result word)
  localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(WORDS - 1);

  // The operand packing below assumes whole words per operand.
  if ((MOD_WIDTH % WORD_WIDTH) != 0) begin : g_bad_width
    $error("rsa_stream_io: MOD_WIDTH must be a multiple of WORD_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [CNT_W-1:0]         r_cnt;
  // operands packed back to back: base, msg, key, modulus (low to high)
  logic [4*MOD_WIDTH-1:0]   r_ops;
  logic [MOD_WIDTH-1:0]     r_result;

  logic                     w_s_hs;
  logic                     w_m_hs;
  logic                     w_r_hs;
  logic                     w_o_hs;
  logic                     w_load_done;
  logic                     w_unload_done;
  logic                     w_skip;
  logic [OP_WORDS-1:0]      w_word_we;

  // Handshakes and phase-completion strobes
  assign w_s_hs        = s_valid & s_ready;
  assign w_m_hs        = m_valid & m_ready;
  assign w_r_hs        = r_valid & r_ready;
  assign w_o_hs        = o_valid & o_ready;
  assign w_load_done   = w_s_hs & (r_cnt == LOAD_LAST);
  assign w_unload_done = w_o_hs & (r_cnt == UNLOAD_LAST);

`ifdef RSA_STREAM_ODD_CHECK_EN
  localparam logic [CNT_W-1:0] MOD_LSW = CNT_W'(3 * WORDS);

  logic w_mod_lsb;
  logic r_err;

  // The modulus LSB is normally already stored when loading ends; with a
  // single-word operand the LSW arrives on the final handshake itself.
  assign w_mod_lsb = (r_cnt == MOD_LSW) ? s_data[0] : r_ops[3*MOD_WIDTH];
  assign w_skip    = w_load_done & ~w_mod_lsb;

  // Error flag: raised on an even-modulus skip, dropped by the next load's first word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_skip) begin
      r_err <= 1'b1;
    end else if (w_s_hs && (r_cnt == '0)) begin
      r_err <= 1'b0;
    end
  end

  assign o_err = r_err;
`else
  assign w_skip = 1'b0;
`endif

  // Per-word write enables for the operand store, one per load word slot
  for (genvar gi = 0; gi < OP_WORDS; gi++) begin : g_word_we
    assign w_word_we[gi] = w_s_hs & (r_cnt == CNT_W'(gi));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_load_done) begin
          w_state_next = w_skip ? ST_UNLOAD : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_m_hs) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_r_hs) begin
          w_state_next = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (w_unload_done) begin
          w_state_next = ST_LOAD;
        end
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  // FSM outputs: each handshake flag is owned by exactly one state
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    r_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      ST_LOAD:   s_ready = 1'b1;
      ST_ISSUE:  m_valid = 1'b1;
      ST_WAIT:   r_ready = 1'b1;
      ST_UNLOAD: o_valid = 1'b1;
      default:   s_ready = 1'b0;
    endcase
  end

  // Word counter shared by load and unload; cleared at the end of each phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_load_done || w_unload_done) begin
      r_cnt <= '0;
    end else if (w_s_hs || w_o_hs) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Operand store: only load handshakes ever write it, so m_* hold between loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ops <= '0;
    end else begin
      for (int i = 0; i < OP_WORDS; i++) begin
        if (w_word_we[i]) begin
          r_ops[i*WORD_WIDTH +: WORD_WIDTH] <= s_data;
        end
      end
    end
  end

  assign m_base    = r_ops[0*MOD_WIDTH +: MOD_WIDTH];
  assign m_msg     = r_ops[1*MOD_WIDTH +: MOD_WIDTH];
  assign m_key     = r_ops[2*MOD_WIDTH +: MOD_WIDTH];
  assign m_modulus = r_ops[3*MOD_WIDTH +: MOD_WIDTH];

  // Result register: captured from the exponentiator, or zeroed on a skip
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= '0;
    end else if (w_r_hs) begin
      r_result <= r_crypto;
    end else if (w_skip) begin
      r_result <= '0;
    end
  end

  // Result word mux: word r_cnt of the result while unloading, zero otherwise
  always_comb begin
    o_data = '0;
    if (r_state == ST_UNLOAD) begin
      for (int i = 0; i < WORDS; i++) begin
        if (r_cnt == CNT_W'(i)) begin
          o_data = r_result[i*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_rsa_stream_io.sv
// tb_rsa_stream_io: randomized, self-checking bench for rsa_stream_io.
// The reference model is plain word concatenation of the host stream into
// operands and plain word slicing of the exponentiator result.
module tb_rsa_stream_io;

  localparam int MW    = 256;
  localparam int WW    = 32;
  localparam int WORDS = MW / WW;
  localparam int NW    = 4 * WORDS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [WW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [MW-1:0] m_base;
  logic [MW-1:0] m_msg;
  logic [MW-1:0] m_key;
  logic [MW-1:0] m_modulus;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [MW-1:0] r_crypto = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [WW-1:0] o_data;
`ifdef RSA_STREAM_ODD_CHECK_EN
  logic          o_err;
`endif

  rsa_stream_io #(.MOD_WIDTH(MW), .WORD_WIDTH(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_base    (m_base),
    .m_msg     (m_msg),
    .m_key     (m_key),
    .m_modulus (m_modulus),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_crypto  (r_crypto),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data)
`ifdef RSA_STREAM_ODD_CHECK_EN
    ,
    .o_err     (o_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [WW-1:0] tx_words [NW];

  task automatic check_val(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Operand k as the host sent it: words k*WORDS .. k*WORDS+WORDS-1, LSW first
  function automatic logic [MW-1:0] exp_op(input int k);
    logic [MW-1:0] v;
    v = '0;
    for (int j = 0; j < WORDS; j++) v[j*WW +: WW] = tx_words[k*WORDS + j];
    return v;
  endfunction

  function automatic logic [MW-1:0] rand_wide();
    logic [MW-1:0] v;
    for (int j = 0; j < WORDS; j++) v[j*WW +: WW] = $urandom();
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ops(input string tag);
    check_val({tag, "_base"}, m_base,    exp_op(0));
    check_val({tag, "_msg"},  m_msg,     exp_op(1));
    check_val({tag, "_key"},  m_key,     exp_op(2));
    check_val({tag, "_mod"},  m_modulus, exp_op(3));
  endtask

  task automatic randomize_words();
    for (int i = 0; i < NW; i++) tx_words[i] = $urandom();
    tx_words[3*WORDS][0] = 1'b1;
  endtask

  task automatic load_words(input int n, input int gap_pct);
    int waited;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        step();
      end
      s_valid = 1'b1;
      s_data  = tx_words[i];
      waited  = 0;
      while (!s_ready && waited < 100) begin
        step();
        waited++;
      end
      if (!s_ready) check_val("s_ready_timeout", 0, 1);
      if (i == NW - 1) check_val("m_valid_before_last", m_valid, 0);
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic load_all(input int gap_pct);
    load_words(NW, gap_pct);
    check_val("m_valid_rise", m_valid, 1);
    check_val("s_ready_after_load", s_ready, 0);
    check_ops("load");
  endtask

  task automatic issue_phase(input int stall);
    for (int c = 0; c < stall; c++) begin
      m_ready  = 1'b0;
      r_valid  = 1'b1;
      r_crypto = rand_wide();
      check_val("issue_m_valid", m_valid, 1);
      check_val("issue_s_ready", s_ready, 0);
      check_val("issue_r_ready", r_ready, 0);
      check_ops("issue_hold");
      step();
    end
    r_valid = 1'b0;
    check_val("issue_m_valid_final", m_valid, 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check_val("wait_m_valid", m_valid, 0);
    check_val("wait_r_ready", r_ready, 1);
  endtask

  task automatic result_phase(input logic [MW-1:0] res, input int delay);
    for (int d = 0; d < delay; d++) begin
      check_val("wait_r_ready_hold", r_ready, 1);
      check_val("wait_o_valid", o_valid, 0);
      step();
    end
    r_valid  = 1'b1;
    r_crypto = res;
    step();
    r_valid  = 1'b0;
    r_crypto = rand_wide();
    check_val("unload_o_valid", o_valid, 1);
    check_val("unload_r_ready", r_ready, 0);
    check_ops("unload_keep");
  endtask

  // mode 0: o_ready always 1; mode 1: toggles 1/0; mode 2: random
  task automatic unload_phase(input logic [MW-1:0] res, input int mode, input int stop_after);
    int idx;
    int c;
    logic rdy;
    logic [MW-1:0] r;
    r   = res;
    idx = 0;
    c   = 0;
    while (idx < stop_after && c < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2) == 0;
        default: rdy = 1'($urandom_range(1));
      endcase
      o_ready = rdy;
      check_val("unload_valid", o_valid, 1);
      check_val("unload_m_valid", m_valid, 0);
      check_val($sformatf("unload_word%0d", idx), o_data, r[idx*WW +: WW]);
      step();
      if (rdy) idx++;
      c++;
    end
    o_ready = 1'b0;
    if (idx < stop_after) check_val("unload_timeout", 0, 1);
    if (stop_after == WORDS) begin
      check_val("back_to_load_s_ready", s_ready, 1);
      check_val("back_to_load_o_valid", o_valid, 0);
    end
  endtask

  task automatic run_txn(input int id, input int gap, input int stall, input int delay, input int mode);
    logic [MW-1:0] res;
    int e0;
    e0 = errors;
    randomize_words();
    res = rand_wide();
    load_all(gap);
    issue_phase(stall);
    result_phase(res, delay);
    unload_phase(res, mode, WORDS);
    $display("txn %0d: gap=%0d stall=%0d delay=%0d mode=%0d new_errors=%0d",
             id, gap, stall, delay, mode, errors - e0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] res;

    // reset state
    rst = 1'b0;
    repeat (3) step();
    check_val("rst_s_ready", s_ready, 1);
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_r_ready", r_ready, 0);
    check_val("rst_o_valid", o_valid, 0);
    check_val("rst_o_data", o_data, 0);
    check_val("rst_m_base", m_base, 0);
    check_val("rst_m_msg", m_msg, 0);
    check_val("rst_m_key", m_key, 0);
    check_val("rst_m_mod", m_modulus, 0);
`ifdef RSA_STREAM_ODD_CHECK_EN
    check_val("rst_o_err", o_err, 0);
`endif
    rst = 1'b1;
    step();

    // directed: words k+1, immediate m_ready, stalled ISSUE, known result
    for (int k = 0; k < NW; k++) tx_words[k] = WW'(k + 1);
    load_all(0);
    check_val("dir_base_lsw", m_base[31:0], 32'd1);
    check_val("dir_base_msw", m_base[255:224], 32'd8);
    check_val("dir_msg_lsw", m_msg[31:0], 32'd9);
    check_val("dir_key_lsw", m_key[31:0], 32'd17);
    check_val("dir_mod_lsw", m_modulus[31:0], 32'd25);
    issue_phase(5);
    res = 256'h0807060504030201;
    result_phase(res, 0);
    unload_phase(res, 1, WORDS);
    $display("txn directed: words k+1, stalled issue, toggling o_ready, errors=%0d", errors);

    // randomized transactions
    for (int t = 0; t < 6; t++) begin
      run_txn(t, $urandom_range(40), $urandom_range(4), $urandom_range(4), t % 3);
    end

    // reset after 10 input words, then a fresh transaction
    randomize_words();
    load_words(10, 0);
    rst = 1'b0;
    step();
    check_val("midload_rst_s_ready", s_ready, 1);
    check_val("midload_rst_m_valid", m_valid, 0);
    check_val("midload_rst_m_base", m_base, 0);
    rst = 1'b1;
    step();
    run_txn(100, 0, 0, 0, 0);

    // reset in the middle of unloading, then a fresh transaction
    randomize_words();
    res = rand_wide();
    load_all(0);
    issue_phase(0);
    result_phase(res, 1);
    unload_phase(res, 0, 3);
    rst = 1'b0;
    step();
    check_val("midunload_rst_o_valid", o_valid, 0);
    check_val("midunload_rst_o_data", o_data, 0);
    check_val("midunload_rst_s_ready", s_ready, 1);
    rst = 1'b1;
    step();
    run_txn(101, 10, 1, 2, 2);

    // even modulus
    randomize_words();
    tx_words[3*WORDS] = 32'h20;
`ifdef RSA_STREAM_ODD_CHECK_EN
    load_words(NW, 0);
    check_val("even_m_valid", m_valid, 0);
    check_val("even_o_err", o_err, 1);
    check_val("even_o_valid", o_valid, 1);
    unload_phase('0, 0, WORDS);
    check_val("even_o_err_hold", o_err, 1);
    randomize_words();
    load_words(1, 0);
    check_val("even_o_err_clear", o_err, 0);
    $display("txn even-modulus: skipped exponentiator, errors=%0d", errors);
`else
    res = rand_wide();
    load_all(0);
    issue_phase(0);
    result_phase(res, 0);
    unload_phase(res, 0, WORDS);
    $display("txn even-modulus: normal path, errors=%0d", errors);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
